// File: rtl/sram512_ctl_pkg.sv
// sram512_ctl_pkg: shared widths, idle pin levels and encodings for the 512x8 SRAM controller.
package sram512_ctl_pkg;
  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 8;
  localparam logic CEN_IDLE = 1'b1;
  localparam logic GWEN_IDLE = 1'b1;
  localparam logic [SRAM_DW-1:0] WEN_IDLE = 8'hFF;
  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic {PORT0, PORT1} port_t;
endpackage

// File: rtl/sram512_clear_seq.sv
// sram512_clear_seq: post-reset clear address counter and sticky done flag.
module sram512_clear_seq
  import sram512_ctl_pkg::*;
#(
  parameter bit SKIP = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [SRAM_AW-1:0] addr,
  output logic               last,
  output logic               done
);
  assign last = &addr;
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr <= '0;
      done <= 1'b0;
    end else begin
      addr <= en ? addr + 1'b1 : addr;
      done <= done | SKIP | (en & last);
    end
endmodule

// File: rtl/sram512_arbiter_ctl.sv
// sram512_arbiter_ctl: two-port arbiter and registered pin sequencer for a 512x8 single-port SRAM.
module sram512_arbiter_ctl
  import sram512_ctl_pkg::*;
#(
  parameter bit                 CLEAR_ON_RESET = 1'b1,
  parameter logic [SRAM_DW-1:0] CLEAR_VALUE    = 8'h00,
  parameter int unsigned        MAX_WAIT       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               p0_valid,
  output logic               p0_ready,
  input  logic               p0_we,
  input  logic [SRAM_AW-1:0] p0_addr,
  input  logic [SRAM_DW-1:0] p0_wdata,
  input  logic [SRAM_DW-1:0] p0_wmask,
  output logic               p0_rvalid,
  output logic [SRAM_DW-1:0] p0_rdata,
  input  logic               p1_valid,
  output logic               p1_ready,
  input  logic               p1_we,
  input  logic [SRAM_AW-1:0] p1_addr,
  input  logic [SRAM_DW-1:0] p1_wdata,
  input  logic [SRAM_DW-1:0] p1_wmask,
  output logic               p1_rvalid,
  output logic [SRAM_DW-1:0] p1_rdata,
  output logic               mem_cen,
  output logic               mem_gwen,
  output logic [SRAM_DW-1:0] mem_wen,
  output logic [SRAM_AW-1:0] mem_a,
  output logic [SRAM_DW-1:0] mem_d,
  input  logic [SRAM_DW-1:0] mem_q,
  output logic               init_done
);
  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  state_t state, state_nx;
  logic [3:0] wait_cnt, wait_nx;
  logic [SRAM_AW-1:0] clr_addr, sel_addr, a_nx;
  logic [SRAM_DW-1:0] sel_wdata, sel_wmask, wen_nx, d_nx;
  logic clr_last, run, hold, g0, g1, sel_we, cen_nx, gwen_nx, rd_nx;
  logic s1_v, s2_v;
  port_t s1_id, s2_id;

  sram512_clear_seq #(.SKIP(!CLEAR_ON_RESET)) u_clr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == CLEAR),
    .addr (clr_addr),
    .last (clr_last),
    .done (init_done)
  );

  always_ff @(posedge clk)
    state <= !rst_n ? (CLEAR_ON_RESET ? CLEAR : RUN) : state_nx;

  always_comb state_nx = (state == CLEAR && clr_last) ? RUN : state;

  // Starved p1 overrides p0 once it has waited MAX_WAIT cycles.
  always_comb begin
    run = state == RUN;
    hold = wait_cnt == WMAX && p1_valid;
    g1 = run && p1_valid && (hold || !p0_valid);
    g0 = run && p0_valid && !hold;
    sel_we = g1 ? p1_we : p0_we;
    sel_addr = g1 ? p1_addr : p0_addr;
    sel_wdata = g1 ? p1_wdata : p0_wdata;
    sel_wmask = g1 ? p1_wmask : p0_wmask;
    cen_nx = !run ? 1'b0 : (g0 || g1) ? 1'b0 : CEN_IDLE;
    gwen_nx = !run ? 1'b0 : (g0 || g1) && sel_we ? 1'b0 : GWEN_IDLE;
    wen_nx = !run ? '0 : (g0 || g1) && sel_we ? ~sel_wmask : WEN_IDLE;
    a_nx = !run ? clr_addr : (g0 || g1) ? sel_addr : mem_a;
    d_nx = !run ? CLEAR_VALUE : (g0 || g1) && sel_we ? sel_wdata : mem_d;
    rd_nx = (g0 || g1) && !sel_we;
    wait_nx = (!p1_valid || g1) ? 4'd0 : wait_cnt == WMAX ? wait_cnt : wait_cnt + 1'b1;
  end

  assign p0_ready = g0;
  assign p1_ready = g1;
  assign p0_rvalid = s2_v && s2_id == PORT0;
  assign p1_rvalid = s2_v && s2_id == PORT1;
  assign p0_rdata = mem_q;
  assign p1_rdata = mem_q;

  // Stage 1 tracks the issued read, stage 2 the cycle the macro's Q is valid.
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem_cen <= CEN_IDLE;
      mem_gwen <= GWEN_IDLE;
      mem_wen <= WEN_IDLE;
      mem_a <= '0;
      mem_d <= '0;
      wait_cnt <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_id <= PORT0;
      s2_id <= PORT0;
    end else begin
      mem_cen <= cen_nx;
      mem_gwen <= gwen_nx;
      mem_wen <= wen_nx;
      mem_a <= a_nx;
      mem_d <= d_nx;
      wait_cnt <= wait_nx;
      s1_v <= rd_nx;
      s2_v <= s1_v;
      s1_id <= g1 ? PORT1 : PORT0;
      s2_id <= s1_id;
    end
endmodule

// File: tb/tb_sram512_arbiter_ctl.sv
// tb_sram512_arbiter_ctl: clear/reset sequences, a directed vector table and random traffic
// checked against a memory-level reference model.
`timescale 1ns/1ps
module tb_sram512_arbiter_ctl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
  logic [8:0] p0_addr = 0, p1_addr = 0;
  logic [7:0] p0_wdata = 0, p0_wmask = 0, p1_wdata = 0, p1_wmask = 0;
  logic p0_ready, p1_ready, p0_rvalid, p1_rvalid, mem_cen, mem_gwen, init_done;
  logic [7:0] p0_rdata, p1_rdata, mem_wen, mem_d, mem_q;
  logic [8:0] mem_a;
  logic [7:0] sram [512];
  int total = 0, bad = 0;

  typedef struct {
    logic v0, we0; logic [8:0] a0; logic [7:0] d0, m0;
    logic v1, we1; logic [8:0] a1; logic [7:0] d1, m1;
    logic r0, r1, cen, gwen; logic [7:0] wen; logic [8:0] a; logic [7:0] d;
    logic rv0, rv1; logic [7:0] rd;
  } vec_t;
  typedef struct { int due; bit port; logic [7:0] data; } rd_t;
  vec_t tbl[$];
  rd_t pend[$];
  logic [7:0] shadow [512];

  always #5 clk = ~clk;

  sram512_arbiter_ctl #(.CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'hA5), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_wmask(p0_wmask), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_wmask(p1_wmask), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_cen(mem_cen), .mem_gwen(mem_gwen), .mem_wen(mem_wen), .mem_a(mem_a),
    .mem_d(mem_d), .mem_q(mem_q), .init_done(init_done)
  );

  // Behavioural macro: synchronous, bit-masked writes, Q updated only by reads.
  always @(posedge clk)
    if (!mem_cen) begin
      if (!mem_gwen) sram[mem_a] <= (sram[mem_a] & mem_wen) | (mem_d & ~mem_wen);
      else mem_q <= sram[mem_a];
    end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pins(string nm, logic cen, logic gwen, logic [7:0] wen, logic [8:0] a, logic [7:0] d);
    chk({nm, "_cen"}, mem_cen, cen);
    chk({nm, "_gwen"}, mem_gwen, gwen);
    chk({nm, "_wen"}, mem_wen, wen);
    chk({nm, "_a"}, mem_a, a);
    chk({nm, "_d"}, mem_d, d);
  endtask

  initial begin
    int n;
    int wcnt;
    int cyc;
    logic m0, m1, hld, er0, er1, we;
    logic [8:0] ad;
    logic [7:0] dd, mm, erd, e_wen, e_d;
    logic [8:0] e_a;
    logic e_cen, e_gwen;

    // Directed vectors: one row per cycle, pins/rvalid checked after the edge.
    tbl.push_back('{1,1,'h1FF,'h3C,'hFF, 0,0,0,0,0, 1,0, 0,0,'h00,'h1FF,'h3C, 0,0,0});
    tbl.push_back('{1,0,'h1FF,0,0, 0,0,0,0,0, 1,0, 0,1,'hFF,'h1FF,'h3C, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0, 0,0, 1,1,'hFF,'h1FF,'h3C, 1,0,'h3C});
    tbl.push_back('{1,0,'h1FF,0,0, 1,0,'h0AA,0,0, 1,0, 0,1,'hFF,'h1FF,'h3C, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,'h0AA,0,0, 0,1, 0,1,'hFF,'h0AA,'h3C, 1,0,'h3C});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0, 0,0, 1,1,'hFF,'h0AA,'h3C, 0,1,'hA5});
    for (int k = 1; k <= 10; k++) begin
      logic gp1, pp1, pp0;
      gp1 = (k % 5) == 0;
      pp1 = k > 1 && ((k - 1) % 5) == 0;
      pp0 = k > 1 && !pp1;
      tbl.push_back('{1,0,'h001,0,0, 1,0,'h002,0,0, !gp1,gp1, 0,1,'hFF,gp1 ? 9'h002 : 9'h001,'h3C, pp0,pp1,'hA5});
    end
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0, 0,0, 1,1,'hFF,'h002,'h3C, 0,1,'hA5});
    tbl.push_back('{1,1,'h005,'hFF,'hFF, 0,0,0,0,0, 1,0, 0,0,'h00,'h005,'hFF, 0,0,0});
    tbl.push_back('{1,1,'h005,'h00,'h0F, 0,0,0,0,0, 1,0, 0,0,'hF0,'h005,'h00, 0,0,0});
    tbl.push_back('{1,0,'h005,0,0, 0,0,0,0,0, 1,0, 0,1,'hFF,'h005,'h00, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0, 0,0, 1,1,'hFF,'h005,'h00, 1,0,'hF0});
    tbl.push_back('{0,0,0,0,0, 1,1,'h005,'h00,'h00, 0,1, 0,0,'hFF,'h005,'h00, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 1,0,'h005,0,0, 0,1, 0,1,'hFF,'h005,'h00, 0,0,0});
    tbl.push_back('{0,0,0,0,0, 0,0,0,0,0, 0,0, 1,1,'hFF,'h005,'h00, 0,1,'hF0});

    // Reset state, with a pending p0 read that must wait for the clear.
    p0_valid = 1; p0_we = 0; p0_addr = 9'd300;
    repeat (3) @(posedge clk);
    #1;
    pins("rst", 1, 1, 8'hFF, 0, 0);
    chk("rst_ready0", p0_ready, 0);
    chk("rst_ready1", p1_ready, 0);
    chk("rst_rvalid0", p0_rvalid, 0);
    chk("rst_init", init_done, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1;
      pins($sformatf("clr%0d", i), 0, 0, 8'h00, 9'(i), 8'hA5);
      chk($sformatf("clr%0d_init", i), init_done, i == 511);
      chk($sformatf("clr%0d_ready0", i), p0_ready, i == 511);
    end
    @(posedge clk);
    #1;
    pins("rd300", 0, 1, 8'hFF, 9'd300, 8'hA5);
    p0_valid = 0;
    @(posedge clk);
    #1;
    chk("rd300_rvalid0", p0_rvalid, 1);
    chk("rd300_rdata", p0_rdata, 8'hA5);
    chk("rd300_rvalid1", p1_rvalid, 0);
    @(posedge clk);
    #1;
    chk("rd300_pulse", p0_rvalid, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      p0_valid = tbl[k].v0; p0_we = tbl[k].we0; p0_addr = tbl[k].a0; p0_wdata = tbl[k].d0; p0_wmask = tbl[k].m0;
      p1_valid = tbl[k].v1; p1_we = tbl[k].we1; p1_addr = tbl[k].a1; p1_wdata = tbl[k].d1; p1_wmask = tbl[k].m1;
      #1;
      chk($sformatf("tbl%0d_ready0", k), p0_ready, tbl[k].r0);
      chk($sformatf("tbl%0d_ready1", k), p1_ready, tbl[k].r1);
      @(posedge clk);
      #1;
      pins($sformatf("tbl%0d", k), tbl[k].cen, tbl[k].gwen, tbl[k].wen, tbl[k].a, tbl[k].d);
      chk($sformatf("tbl%0d_rvalid0", k), p0_rvalid, tbl[k].rv0);
      chk($sformatf("tbl%0d_rvalid1", k), p1_rvalid, tbl[k].rv1);
      if (tbl[k].rv0 || tbl[k].rv1)
        chk($sformatf("tbl%0d_rdata", k), tbl[k].rv0 ? p0_rdata : p1_rdata, tbl[k].rd);
    end

    // Random traffic against a shadow memory and a queue of due read responses.
    for (int i = 0; i < 512; i++) shadow[i] = 8'hA5;
    shadow[9'h1FF] = 8'h3C;
    shadow[5] = 8'hF0;
    wcnt = 0; cyc = 0;
    e_cen = 1; e_gwen = 1; e_wen = 8'hFF; e_a = 9'h005; e_d = 8'h00;
    for (int it = 0; it < 2002; it++) begin
      @(negedge clk);
      p0_valid = it < 2000 && $urandom_range(0, 9) < 6;
      p1_valid = it < 2000 && $urandom_range(0, 9) < 5;
      p0_we = 1'($urandom_range(0, 1)); p1_we = 1'($urandom_range(0, 1));
      p0_addr = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      p1_addr = $urandom_range(0, 3) == 0 ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15));
      p0_wdata = 8'($urandom); p1_wdata = 8'($urandom);
      p0_wmask = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      p1_wmask = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      #1;
      hld = wcnt == 4 && p1_valid;
      m1 = p1_valid && (hld || !p0_valid);
      m0 = p0_valid && !hld;
      chk($sformatf("rnd%0d_ready0", it), p0_ready, m0);
      chk($sformatf("rnd%0d_ready1", it), p1_ready, m1);
      if (m0 || m1) begin
        we = m1 ? p1_we : p0_we;
        ad = m1 ? p1_addr : p0_addr;
        dd = m1 ? p1_wdata : p0_wdata;
        mm = m1 ? p1_wmask : p0_wmask;
        e_cen = 0; e_a = ad;
        if (we) begin
          e_gwen = 0; e_wen = ~mm; e_d = dd;
          shadow[ad] = (shadow[ad] & ~mm) | (dd & mm);
        end else begin
          e_gwen = 1; e_wen = 8'hFF;
          pend.push_back('{cyc + 2, m1, shadow[ad]});
        end
      end else begin
        e_cen = 1; e_gwen = 1; e_wen = 8'hFF;
      end
      wcnt = (!p1_valid || m1) ? 0 : (wcnt < 4 ? wcnt + 1 : 4);
      @(posedge clk);
      cyc++;
      #1;
      pins($sformatf("rnd%0d", it), e_cen, e_gwen, e_wen, e_a, e_d);
      er0 = 0; er1 = 0; erd = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        er0 = !pend[0].port; er1 = pend[0].port; erd = pend[0].data;
        void'(pend.pop_front());
      end
      chk($sformatf("rnd%0d_rvalid0", it), p0_rvalid, er0);
      chk($sformatf("rnd%0d_rvalid1", it), p1_rvalid, er1);
      if (er0 || er1) chk($sformatf("rnd%0d_rdata", it), er0 ? p0_rdata : p1_rdata, erd);
    end
    chk("rnd_drained", pend.size(), 0);

    // Reset right after a read is accepted: the response must never appear.
    @(negedge clk);
    p0_valid = 1; p0_we = 0; p0_addr = 9'd1; p1_valid = 0;
    #1;
    chk("mid_ready0", p0_ready, 1);
    @(posedge clk);
    #1;
    p0_valid = 0; rst_n = 0;
    @(posedge clk);
    #1;
    chk("mid_rvalid0_a", p0_rvalid, 0);
    chk("mid_rvalid1_a", p1_rvalid, 0);
    @(posedge clk);
    #1;
    chk("mid_rvalid0_b", p0_rvalid, 0);
    chk("mid_init", init_done, 0);
    pins("mid_rst", 1, 1, 8'hFF, 0, 0);

    // Reset during clear at address 200: counter restarts from 0.
    @(negedge clk) rst_n = 1;
    repeat (201) @(posedge clk);
    #1;
    chk("clr200_a", mem_a, 9'd200);
    rst_n = 0;
    @(posedge clk);
    #1;
    pins("clr200_rst", 1, 1, 8'hFF, 0, 0);
    chk("clr200_init", init_done, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    pins("reclr0", 0, 0, 8'h00, 0, 8'hA5);
    @(posedge clk);
    #1;
    chk("reclr1_a", mem_a, 9'd1);
    n = 0;
    while (!init_done && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reclr_init", init_done, 1);
    chk("reclr_len", n, 510);
    chk("reclr_last_a", mem_a, 9'd511);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
